jtag_debug_bridge: RTL
======================

# jtag_debug_bridge

Parametrised successor to the LabARC virtual-JTAG readout block. It sits between the Altera `vJTAG` IP instance and the top-level design. It decodes host commands shifted into a CMD_W-bit data register and returns any of NCH probe words, up to DATA_W bits each, serially on `tdo`. It also drives NSWI virtual switches and adds a snapshot mode that freezes all probes atomically, so multi-word reads are coherent.

## Interface
- CMD_W, 8: command register width; opcode is the top 2 bits.
- DATA_W, 32: probe word width, returned in full per scan.
- NCH, 16: probe channel count; must be ≤ 2^(CMD_W-2).
- NSWI, 8: virtual switch count; must be ≤ 2^(CMD_W-3).
- `tck`  in  1  JTAG clock from `vJTAG`; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tdi`  in  1  serial data from `vJTAG`.
- `ir_in`  in  1  1 selects the command/data DR; 0 selects bypass.
- `sdr`  in  1  virtual Shift-DR state, sampled on posedge `tck`.
- `udr`  in  1  virtual Update-DR state, sampled on posedge `tck`.
- `tdo`  out  1  serial data to `vJTAG`.
- `probe`  in  NCH×DATA_W  unpacked array of live probe words.
- `swi`  out  NSWI  virtual switch outputs.
- `snap_cnt`  out  DATA_W  number of snapshots taken; wraps.

## Operation
- Reset values: `tdo`=0, `swi`=0, `snap_cnt`=0, command=0 (read channel 0), output shift register=0, all snapshot words=0, bypass flop=0, bit counter=0.
- Shift (`sdr`=1, `ir_in`=1):
  - `cmd_sr` <= {`tdi`, `cmd_sr`[CMD_W-1:1]}.
  - `oreg` shifts right with 0 fill.
  - The bit counter increments and saturates at CMD_W.
- Bypass: the bypass flop <= `tdi` on every edge. `tdo` = bypass flop whenever `ir_in`=0.
- `tdo` = `oreg`[0] when `ir_in`=1. Data leaves LSB first. After DATA_W bits, `tdo` is 0.
- Update (`udr`=1, `ir_in`=1):
  - If bit counter ≥ CMD_W, command <= `cmd_sr`. The last CMD_W bits shifted form the command.
  - Otherwise the scan is short: command is unchanged and no side effect occurs.
  - Bit counter clears.
  - `oreg` loads the word selected by the resulting command, sampled this edge.
- Opcodes (cmd[CMD_W-1:CMD_W-2]):
  - 00 READ: `oreg` <= `probe`[cmd[CMD_W-3:0]]. Index ≥ NCH loads 0.
  - 01 SWI: `swi`[cmd[CMD_W-3:1]] <= cmd[0]. Index ≥ NSWI is ignored. `oreg` <= zero-extended `swi` after the update.
  - 10 SNAP: all `probe` words copy into the snapshot bank; `snap_cnt` += 1. `oreg` <= new `snap_cnt`.
  - 11 SREAD: `oreg` <= snapshot[cmd[CMD_W-3:0]]. Index ≥ NCH loads 0.
- A command re-executes only when a full-length scan updates it. A short scan reloads `oreg` from the current command, with no SWI or SNAP side effect.
- `udr` and `sdr` high in the same cycle (illegal in JTAG): `udr` wins and the shift is dropped.
- `udr` with `ir_in`=0: no effect on command, `oreg`, `swi` or the snapshot bank.

## Timing
- Everything is synchronous to posedge `tck` except `reset_n`.
- Data returned in a scan was sampled at the Update-DR of the previous scan; latency is one scan.
- `swi` and `snap_cnt` change on the first `tck` edge with `udr`=1. There is no intermediate glitch; they are registered.
- `tdo` is valid from the first `sdr` cycle after update.
- `reset_n` low mid-scan: the partial command is discarded and all state returns to reset values. After release, the first full scan behaves as after power-up.
- `snap_cnt` wraps from 2^DATA_W-1 to 0.

## Structure
- Package `jtag_dbg_pkg`:
  - `opcode_e` enum: READ, SWI, SNAP, SREAD.
  - Default CMD_W.
  - Field-extraction functions for opcode, index and value.
- Sub-module `jtag_dbg_snapshot`: NCH×DATA_W register bank with a capture strobe, read index and async reset.
- Elaboration assertions check the NCH and NSWI limits.

## Test plan
Parameters for all scenarios: CMD_W=8, DATA_W=32, NCH=16, NSWI=8.
- READ: `probe`[3]=0xDEADBEEF, scan 32 bits ending in cmd 0x03. The next 32-bit scan returns 0xDEADBEEF LSB-first. cmd 0x13 (index 19) returns 0.
- SWI: cmd 0x4B gives `swi`=0x20 one edge after `udr`. cmd 0x4A gives `swi`=0x00. cmd 0x5F (index 15) leaves `swi` unchanged.
- SNAP:
  - Set `probe`[2]=0x11, then send cmd 0x80. The next scan returns 1 and `snap_cnt`=1.
  - Set `probe`[2]=0x22, then send cmd 0xC2. The next scan returns 0x11.
  - Send cmd 0x02. The next scan returns 0x22.
- Short scan: after cmd 0x4B, a 5-bit scan with `udr` leaves the command unchanged and `swi` unchanged. `oreg` reloads with zero-extended `swi`.
- Bypass: `ir_in`=0, `tdi` pattern 1,0,1,1. `tdo` follows it delayed exactly one `tck`; `swi` is unaffected.
- Reset mid-scan: assert `reset_n` after 4 of 8 shift bits. `tdo`, `swi` and `snap_cnt` are 0. The next full cmd 0x01 scan reads `probe`[1] correctly.

Source files
------------

// File: rtl/jtag_dbg_pkg.sv
// Shared types and command-field helpers for the virtual-JTAG debug bridge.
// Commands are CMD_W bits wide with the opcode in the top two bits.
// Field helpers take a zero-extended command plus its real width.
package jtag_dbg_pkg;

  localparam int unsigned CMD_W_DEFAULT = 8;
  localparam int unsigned MAX_CMD_W     = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SWI   = 2'b01,
    OP_SNAP  = 2'b10,
    OP_SREAD = 2'b11
  } opcode_e;

  function automatic opcode_e get_opcode(input logic [MAX_CMD_W-1:0] cmd, input int unsigned cmd_w);
    return opcode_e'(cmd[cmd_w-1 -: 2]);
  endfunction

  // Probe / snapshot index: everything below the opcode.
  function automatic int unsigned get_index(input logic [MAX_CMD_W-1:0] cmd, input int unsigned cmd_w);
    return cmd & ((32'd1 << (cmd_w - 2)) - 32'd1);
  endfunction

  // Switch index: the bits between the opcode and the value bit.
  function automatic int unsigned get_swi_index(input logic [MAX_CMD_W-1:0] cmd, input int unsigned cmd_w);
    return (cmd >> 1) & ((32'd1 << (cmd_w - 3)) - 32'd1);
  endfunction

  function automatic logic get_value(input logic [MAX_CMD_W-1:0] cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/jtag_dbg_snapshot.sv
// Snapshot bank: captures all probe words atomically on a single strobe.
// Latency: capture lands on the strobe edge; read port is combinational.
// No backpressure; out-of-range read index returns zero.
module jtag_dbg_snapshot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] probe_i [NCH],
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] bank_q [NCH];

  // Copy every probe word in the same edge so multi-word reads stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) bank_q[i] <= '0;
    end else if (cap_i) begin
      bank_q <= probe_i;
    end
  end

  assign rd_dat_o = (32'(rd_idx_i) < NCH) ? bank_q[rd_idx_i] : '0;

endmodule

// File: rtl/jtag_debug_bridge.sv
// Virtual-JTAG debug bridge: command DR decode, probe/snapshot readout, switches.
// Latency: one scan (data loaded at Update-DR is shifted out on the next scan).
// No backpressure; the host paces everything through tck/sdr/udr.
module jtag_debug_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned CMD_W  = CMD_W_DEFAULT,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 16,
  parameter int unsigned NSWI   = 8
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic              tdi,
  input  logic              ir_in,
  input  logic              sdr,
  input  logic              udr,
  output logic              tdo,
  input  logic [DATA_W-1:0] probe [NCH],
  output logic [NSWI-1:0]   swi,
  output logic [DATA_W-1:0] snap_cnt
);

  localparam int unsigned BC_W  = $clog2(CMD_W + 1);
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW_W  = (NSWI > 1) ? $clog2(NSWI) : 1;

  if (NCH > (32'd1 << (CMD_W - 2))) begin : g_bad_nch
    $error("jtag_debug_bridge: NCH exceeds the command index range");
  end
  if (NSWI > (32'd1 << (CMD_W - 3))) begin : g_bad_nswi
    $error("jtag_debug_bridge: NSWI exceeds the switch index range");
  end
  if (CMD_W > MAX_CMD_W || CMD_W < 3) begin : g_bad_cmdw
    $error("jtag_debug_bridge: CMD_W out of supported range");
  end

  logic [CMD_W-1:0]  cmd_sr_q, cmd_q, cmd_d;
  logic [DATA_W-1:0] oreg_q, oreg_d;
  logic [BC_W-1:0]   bitcnt_q;
  logic              byp_q;
  logic [NSWI-1:0]   swi_q, swi_d;
  logic [DATA_W-1:0] snap_cnt_q, snap_cnt_d;

  logic                 upd, shift, full_scan, snap_cap;
  logic [MAX_CMD_W-1:0] cmd_ext;
  opcode_e              op;
  int unsigned          idx, swi_idx;
  logic                 idx_ok;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_W-1:0]    snap_rd_dat;

  // Update beats shift when the host asserts both in one cycle.
  assign upd       = ir_in && udr;
  assign shift     = ir_in && sdr && !udr;
  assign full_scan = (bitcnt_q >= BC_W'(CMD_W));

  // Resolve the command in force after this update and its side effects.
  always_comb begin
    cmd_d   = full_scan ? cmd_sr_q : cmd_q;
    cmd_ext = '0;
    cmd_ext[CMD_W-1:0] = cmd_d;
    op      = get_opcode(cmd_ext, CMD_W);
    idx     = get_index(cmd_ext, CMD_W);
    swi_idx = get_swi_index(cmd_ext, CMD_W);
    idx_ok  = (idx < NCH);
    rd_idx  = IDX_W'(idx);

    // Short scans reload oreg only; switches and snapshots need a full scan.
    swi_d = swi_q;
    if (full_scan && op == OP_SWI && swi_idx < NSWI) begin
      swi_d[SW_W'(swi_idx)] = get_value(cmd_ext);
    end
    snap_cap   = upd && full_scan && (op == OP_SNAP);
    snap_cnt_d = snap_cnt_q + (snap_cap ? DATA_W'(1) : '0);

    oreg_d = '0;
    case (op)
      OP_READ:  oreg_d = idx_ok ? probe[rd_idx] : '0;
      OP_SWI:   oreg_d = DATA_W'(swi_d);
      OP_SNAP:  oreg_d = snap_cnt_d;
      OP_SREAD: oreg_d = idx_ok ? snap_rd_dat : '0;
      default:  oreg_d = '0;
    endcase
  end

  jtag_dbg_snapshot #(
    .DATA_W (DATA_W),
    .NCH    (NCH),
    .IDX_W  (IDX_W)
  ) u_snapshot (
    .clk      (tck),
    .rst_n    (reset_n),
    .cap_i    (snap_cap),
    .probe_i  (probe),
    .rd_idx_i (rd_idx),
    .rd_dat_o (snap_rd_dat)
  );

  // Shift/update state machine of the command/data DR plus the bypass flop.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      cmd_sr_q   <= '0;
      cmd_q      <= '0;
      oreg_q     <= '0;
      bitcnt_q   <= '0;
      byp_q      <= 1'b0;
      swi_q      <= '0;
      snap_cnt_q <= '0;
    end else begin
      byp_q <= tdi;
      if (upd) begin
        cmd_q      <= cmd_d;
        oreg_q     <= oreg_d;
        bitcnt_q   <= '0;
        swi_q      <= swi_d;
        snap_cnt_q <= snap_cnt_d;
      end else if (shift) begin
        cmd_sr_q <= {tdi, cmd_sr_q[CMD_W-1:1]};
        oreg_q   <= {1'b0, oreg_q[DATA_W-1:1]};
        if (!full_scan) bitcnt_q <= bitcnt_q + BC_W'(1);
      end
    end
  end

  assign tdo      = ir_in ? oreg_q[0] : byp_q;
  assign swi      = swi_q;
  assign snap_cnt = snap_cnt_q;

endmodule
